// File: rtl/led_axil_slave.sv
// AXI4-Lite LED peripheral: four 32-bit registers (LED_VALUE, CTRL,
// BLINK_DIV, SCRATCH) with byte-strobed writes and a blink prescaler.
// Ports: ACLK/ARESETN (sync, active-low), AXI4-Lite AW/W/B/AR/R
// channels (AWPROT/ARPROT and address bits [1:0] ignored), and
// led_out, the registered LED drive.
module led_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [LED_WIDTH-1:0]            led_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_DATA
    } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DW-1:0] led_value, ctrl, blink_div, scratch;
    logic [DW-1:0] led_nxt, ctrl_nxt, div_nxt, scr_nxt;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] presc;
    logic          phase;
    logic [1:0]    wsel, rsel;
    logic          wr_commit, div_wr, en_rise;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR, ARADDR};

    assign wsel = AWADDR[3:2];
    assign rsel = ARADDR[3:2];

    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0] old,
        input logic [DW-1:0] data,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) r[k*8 +: 8] = data[k*8 +: 8];
        end
        return r;
    endfunction

    // Write FSM
    always_ff @(posedge ACLK) begin
        if (!ARESETN) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next    = w_state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        wr_commit = 1'b0;
        unique case (w_state)
            W_IDLE: if (AWVALID && WVALID) w_next = W_ACK;
            W_ACK: begin
                AWREADY   = 1'b1;
                WREADY    = 1'b1;
                wr_commit = 1'b1;
                w_next    = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign BRESP = 2'b00;

    // Read FSM
    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: if (ARVALID) r_next = R_ACK;
            R_ACK: begin
                ARREADY = 1'b1;
                r_next  = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign RRESP = 2'b00;

    // Register file next-state
    always_comb begin
        led_nxt = led_value;
        ctrl_nxt = ctrl;
        div_nxt = blink_div;
        scr_nxt = scratch;
        if (wr_commit) begin
            unique case (wsel)
                2'd0: led_nxt  = merge(led_value, WDATA, WSTRB);
                2'd1: ctrl_nxt = merge(ctrl, WDATA, WSTRB);
                2'd2: div_nxt  = merge(blink_div, WDATA, WSTRB);
                2'd3: scr_nxt  = merge(scratch, WDATA, WSTRB);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (rsel)
            2'd0: rd_mux = led_value;
            2'd1: rd_mux = ctrl;
            2'd2: rd_mux = blink_div;
            2'd3: rd_mux = scratch;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            led_value <= '0;
            ctrl      <= '0;
            blink_div <= '0;
            scratch   <= '0;
            RDATA     <= '0;
        end else begin
            led_value <= led_nxt;
            ctrl      <= ctrl_nxt;
            blink_div <= div_nxt;
            scratch   <= scr_nxt;
            // Sampled before this edge's write lands: collisions read old data.
            if (r_state == R_ACK) RDATA <= rd_mux;
        end
    end

    // Blink prescaler
    assign div_wr  = wr_commit && (wsel == 2'd2);
    assign en_rise = ctrl_nxt[0] && !ctrl[0];

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            presc <= '0;
            phase <= 1'b1;
        end else if (div_wr || en_rise) begin
            presc <= div_nxt;
            phase <= 1'b1;
        end else if (!ctrl[0]) begin
            presc <= blink_div;
            phase <= 1'b1;
        end else if (presc == '0) begin
            presc <= blink_div;
            phase <= ~phase;
        end else begin
            presc <= presc - 1'b1;
        end
    end

    // A just-disabled blinker may still hold phase=0 for one cycle;
    // gating with blink_en keeps the output steady immediately.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            led_out <= '0;
        end else begin
            led_out <= ((phase || !ctrl[0]) ? led_value[LED_WIDTH-1:0]
                                            : '0)
                       ^ {LED_WIDTH{ctrl[1]}};
        end
    end

endmodule

// File: tb/tb_led_axil_slave.sv
// Self-checking bench for led_axil_slave: directed and randomized
// AXI4-Lite traffic against a register/blink model kept in the bench.
module tb_led_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [7:0]  led_out;

    led_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .LED_WIDTH(8)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .led_out(led_out)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: register contents plus the cycle at which blinking restarted.
    logic [31:0] m_reg [4];
    longint      m_rst_cyc = 0;
    bit          chk_on = 1'b0;
    logic [7:0]  exp_led = 8'h00;

    logic [7:0] pat_a5 [12] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                8'h00, 8'h00, 8'h00, 8'h00,
                                8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0] pat_5a [12] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A,
                                8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                8'h5A, 8'h5A, 8'h5A, 8'h5A};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    // Phase k of length DIV+1 since restart; even phases are "on".
    function automatic logic [7:0] m_led(input int c);
        bit     en, inv, ph;
        longint per;
        en  = m_reg[1][0];
        inv = m_reg[1][1];
        per = longint'({32'h0, m_reg[2]}) + 1;
        ph  = !en || ((((longint'(c) - m_rst_cyc) / per) % 2) == 0);
        return (ph ? m_reg[0][7:0] : 8'h00) ^ (inv ? 8'hFF : 8'h00);
    endfunction

    task automatic m_write(input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        logic [31:0] old;
        old = m_reg[a];
        for (int k = 0; k < 4; k++) begin
            if (s[k]) m_reg[a][k*8 +: 8] = d[k*8 +: 8];
        end
        if (a == 2'd2 || (a == 2'd1 && m_reg[1][0] && !old[0]))
            m_rst_cyc = cyc;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_reg[k] = '0;
        m_rst_cyc = cyc;
    endtask

    // led_out seen in cycle c reflects model state of cycle c-1.
    always @(negedge ACLK) begin
        if (chk_on) begin
            chk("led_out", {24'h0, led_out}, {24'h0, exp_led});
            chk("BRESP", {30'h0, BRESP}, 32'h0);
            chk("RRESP", {30'h0, RRESP}, 32'h0);
        end
        exp_led = ARESETN ? m_led(cyc) : 8'h00;
    end

    task automatic axi_write(input logic [1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int bdly);
        @(posedge ACLK); #1;
        AWADDR  = {a, 2'($urandom_range(0, 3))};
        AWPROT  = 3'($urandom_range(0, 7));
        WDATA   = d;
        WSTRB   = s;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        chk("awready_idle", {31'h0, AWREADY}, 32'h0);
        @(posedge ACLK); #1;
        chk("aw_w_ready", {30'h0, AWREADY, WREADY}, 32'h3);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        m_write(a, d, s);
        chk("aw_w_pulse", {30'h0, AWREADY, WREADY}, 32'h0);
        chk("bvalid", {31'h0, BVALID}, 32'h1);
        repeat (bdly) begin
            @(posedge ACLK); #1;
            chk("bvalid_hold", {31'h0, BVALID}, 32'h1);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk("bvalid_done", {31'h0, BVALID}, 32'h0);
    endtask

    task automatic axi_read(input logic [1:0] a, input int rdly,
                            output logic [31:0] got);
        logic [31:0] expv;
        @(posedge ACLK); #1;
        ARADDR  = {a, 2'($urandom_range(0, 3))};
        ARPROT  = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        @(posedge ACLK); #1;
        chk("arready", {31'h0, ARREADY}, 32'h1);
        chk("rvalid_early", {31'h0, RVALID}, 32'h0);
        expv = m_reg[a];
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        chk("arready_pulse", {31'h0, ARREADY}, 32'h0);
        chk("rvalid", {31'h0, RVALID}, 32'h1);
        chk("rdata", RDATA, expv);
        got = RDATA;
        repeat (rdly) begin
            @(posedge ACLK); #1;
            chk("rvalid_hold", {31'h0, RVALID}, 32'h1);
            chk("rdata_hold", RDATA, expv);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        chk("rvalid_done", {31'h0, RVALID}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        m_reset();

        // Reset / idle
        repeat (2) @(posedge ACLK);
        #1 chk_on = 1'b1;
        repeat (8) begin
            chk("rst_ready_valid",
                {27'h0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 32'h0);
            @(posedge ACLK); #1;
        end
        ARESETN = 1'b1;
        m_reset();
        for (int a = 0; a < 4; a++) begin
            axi_read(2'(a), 0, got);
            chk("rst_readback", got, 32'h0);
        end

        // Sequential write/readback
        for (int a = 0; a < 4; a++) axi_write(2'(a), 32'(a + 1), 4'hF, 0);
        for (int a = 0; a < 4; a++) begin
            axi_read(2'(a), 0, got);
            chk("seq_readback", got, 32'(a + 1));
        end

        // Byte strobes
        axi_write(2'd3, 32'hAABBCCDD, 4'hF, 0);
        axi_write(2'd3, 32'h11223344, 4'h5, 1);
        axi_read(2'd3, 0, got);
        chk("strobe_merge", got, 32'hAA22CC44);
        axi_write(2'd3, 32'hFFFFFFFF, 4'h0, 0);
        axi_read(2'd3, 0, got);
        chk("strobe_zero", got, 32'hAA22CC44);

        // Write back-pressure with a second write queued
        @(posedge ACLK); #1;
        AWADDR = 4'h0; WDATA = 32'hC3; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        chk("bp_ready", {30'h0, AWREADY, WREADY}, 32'h3);
        @(posedge ACLK); #1;
        m_write(2'd0, 32'hC3, 4'hF);
        WDATA = 32'h3C;
        chk("bp_bvalid", {31'h0, BVALID}, 32'h1);
        repeat (5) begin
            @(posedge ACLK); #1;
            chk("bp_bvalid_hold", {31'h0, BVALID}, 32'h1);
            chk("bp_awready_blocked", {31'h0, AWREADY}, 32'h0);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk("bp_bvalid_done", {31'h0, BVALID}, 32'h0);
        chk("bp_awready_idle", {31'h0, AWREADY}, 32'h0);
        @(posedge ACLK); #1;
        chk("bp_second_ready", {30'h0, AWREADY, WREADY}, 32'h3);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        m_write(2'd0, 32'h3C, 4'hF);
        chk("bp_second_bvalid", {31'h0, BVALID}, 32'h1);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        axi_read(2'd0, 5, got);
        chk("bp_readback", got, 32'h3C);

        // Same-register read/write collision returns old data
        fork
            axi_write(2'd3, 32'h12345678, 4'hF, 0);
            axi_read(2'd3, 0, got);
        join
        chk("collision_old", got, 32'hAA22CC44);
        axi_read(2'd3, 0, got);
        chk("collision_new", got, 32'h12345678);

        // Blink
        axi_write(2'd0, 32'hA5, 4'hF, 0);
        axi_write(2'd2, 32'd3, 4'hF, 0);
        axi_write(2'd1, 32'd0, 4'hF, 0);
        axi_write(2'd1, 32'd1, 4'hF, 0);
        for (int i = 0; i < 12; i++) begin
            chk("blink_a5", {24'h0, led_out}, {24'h0, pat_a5[i]});
            @(posedge ACLK); #1;
        end
        axi_write(2'd1, 32'd0, 4'hF, 0);
        for (int i = 0; i < 6; i++) begin
            chk("steady_a5", {24'h0, led_out}, 32'hA5);
            @(posedge ACLK); #1;
        end
        axi_write(2'd1, 32'd3, 4'hF, 0);
        for (int i = 0; i < 12; i++) begin
            chk("blink_inv", {24'h0, led_out}, {24'h0, pat_5a[i]});
            @(posedge ACLK); #1;
        end

        // Reset while BVALID pending
        @(posedge ACLK); #1;
        AWADDR = 4'hC; WDATA = 32'h77; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        chk("mr_ready", {30'h0, AWREADY, WREADY}, 32'h3);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        m_write(2'd3, 32'h77, 4'hF);
        chk("mr_bvalid", {31'h0, BVALID}, 32'h1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        m_reset();
        chk("mr_bvalid_drop", {31'h0, BVALID}, 32'h0);
        chk("mr_led", {24'h0, led_out}, 32'h0);
        ARESETN = 1'b1;
        for (int a = 0; a < 4; a++) begin
            axi_read(2'(a), 0, got);
            chk("mr_readback", got, 32'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int          op;
            logic [1:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            op = $urandom_range(0, 2);
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            if (a == 2'd2) d = 32'($urandom_range(0, 5));
            if (op == 0) axi_read(a, $urandom_range(0, 3), got);
            else         axi_write(a, d, s, $urandom_range(0, 3));
            repeat ($urandom_range(0, 4)) @(posedge ACLK);
        end

        repeat (4) @(posedge ACLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
